// File: rtl/alu_issue.sv
// alu_issue: two-stage (decode D, execute E) issuer in front of a combinational RV32I ALU.
// Define ALU_ISSUE_M_EXT_EN to decode DIV/DIVU/REM/REMU with RISC-V divide corner-case correction.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic [4:0]  alu_operator,
    output logic [31:0] alu_operand1,
    output logic [31:0] alu_operand2,
    input  logic [31:0] alu_result,
    input  logic        alu_result_is_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic [31:0] out_wb_data,
    output logic        out_branch_taken,
    output logic [31:0] out_branch_target,
    output logic        out_illegal
);
    localparam logic [4:0] ALU_OPERATOR_ADD  = 5'd0;
    localparam logic [4:0] ALU_OPERATOR_SUB  = 5'd1;
    localparam logic [4:0] ALU_OPERATOR_XOR  = 5'd2;
    localparam logic [4:0] ALU_OPERATOR_OR   = 5'd3;
    localparam logic [4:0] ALU_OPERATOR_SLL  = 5'd4;
    localparam logic [4:0] ALU_OPERATOR_SRL  = 5'd5;
    localparam logic [4:0] ALU_OPERATOR_SRA  = 5'd6;
    localparam logic [4:0] ALU_OPERATOR_SLT  = 5'd7;
    localparam logic [4:0] ALU_OPERATOR_SLTU = 5'd8;
`ifdef ALU_ISSUE_M_EXT_EN
    localparam logic [4:0] ALU_OPERATOR_DIV  = 5'd9;
    localparam logic [4:0] ALU_OPERATOR_DIVU = 5'd10;
    localparam logic [4:0] ALU_OPERATOR_REM  = 5'd11;
    localparam logic [4:0] ALU_OPERATOR_REMU = 5'd12;
`endif

    typedef enum logic [1:0] {CLS_ARITH, CLS_BRANCH, CLS_ILLEGAL} cls_t;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_u, imm_b;
    logic [4:0]  dec_op;
    logic [31:0] dec_op1, dec_op2;
    cls_t        dec_cls;
    logic        dec_zsense;
    logic        d_valid, e_valid, d_ready, e_ready;
    logic [4:0]  d_op, d_rd;
    logic [31:0] d_op1, d_op2, d_pc, d_imm, e_result;
    logic        d_rd_we, d_zsense;
    cls_t        d_cls;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};

    always_comb begin
        dec_op     = ALU_OPERATOR_ADD;
        dec_op1    = '0;
        dec_op2    = '0;
        dec_cls    = CLS_ILLEGAL;
        dec_zsense = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_op1 = in_rs1_data;
                dec_op2 = (funct7 != 7'h01 && funct3[1:0] == 2'b01) ? {27'b0, in_rs2_data[4:0]} : in_rs2_data;
                dec_cls = CLS_ARITH;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec_op = ALU_OPERATOR_ADD;
                    {7'h20, 3'b000}: dec_op = ALU_OPERATOR_SUB;
                    {7'h00, 3'b001}: dec_op = ALU_OPERATOR_SLL;
                    {7'h00, 3'b010}: dec_op = ALU_OPERATOR_SLT;
                    {7'h00, 3'b011}: dec_op = ALU_OPERATOR_SLTU;
                    {7'h00, 3'b100}: dec_op = ALU_OPERATOR_XOR;
                    {7'h00, 3'b101}: dec_op = ALU_OPERATOR_SRL;
                    {7'h20, 3'b101}: dec_op = ALU_OPERATOR_SRA;
                    {7'h00, 3'b110}: dec_op = ALU_OPERATOR_OR;
`ifdef ALU_ISSUE_M_EXT_EN
                    {7'h01, 3'b100}: dec_op = ALU_OPERATOR_DIV;
                    {7'h01, 3'b101}: dec_op = ALU_OPERATOR_DIVU;
                    {7'h01, 3'b110}: dec_op = ALU_OPERATOR_REM;
                    {7'h01, 3'b111}: dec_op = ALU_OPERATOR_REMU;
`endif
                    default: dec_cls = CLS_ILLEGAL;
                endcase
            end
            7'b0010011: begin
                dec_op1 = in_rs1_data;
                dec_op2 = (funct3[1:0] == 2'b01) ? {27'b0, imm_i[4:0]} : imm_i;
                dec_cls = CLS_ARITH;
                case (funct3)
                    3'b000: dec_op = ALU_OPERATOR_ADD;
                    3'b001: begin
                        dec_op = ALU_OPERATOR_SLL;
                        if (funct7 != 7'h00) dec_cls = CLS_ILLEGAL;
                    end
                    3'b010: dec_op = ALU_OPERATOR_SLT;
                    3'b011: dec_op = ALU_OPERATOR_SLTU;
                    3'b100: dec_op = ALU_OPERATOR_XOR;
                    3'b101: begin
                        dec_op = funct7[5] ? ALU_OPERATOR_SRA : ALU_OPERATOR_SRL;
                        if ({funct7[6], funct7[4:0]} != 6'b0) dec_cls = CLS_ILLEGAL;
                    end
                    3'b110: dec_op = ALU_OPERATOR_OR;
                    default: dec_cls = CLS_ILLEGAL;
                endcase
            end
            7'b0110111: begin
                dec_op2 = imm_u;
                dec_cls = CLS_ARITH;
            end
            7'b0010111: begin
                dec_op1 = in_pc;
                dec_op2 = imm_u;
                dec_cls = CLS_ARITH;
            end
            7'b1100011: begin
                dec_op1    = in_rs1_data;
                dec_op2    = in_rs2_data;
                dec_op     = funct3[2] ? (funct3[1] ? ALU_OPERATOR_SLTU : ALU_OPERATOR_SLT) : ALU_OPERATOR_SUB;
                dec_cls    = (funct3[2:1] == 2'b01) ? CLS_ILLEGAL : CLS_BRANCH;
                // BEQ/BGE/BGEU are taken on a zero result, BNE/BLT/BLTU on non-zero
                dec_zsense = funct3[2] ? funct3[0] : !funct3[0];
            end
            default: ;
        endcase
        if (dec_cls == CLS_ILLEGAL) begin
            dec_op  = ALU_OPERATOR_ADD;
            dec_op1 = '0;
            dec_op2 = '0;
        end
    end

    assign e_ready  = !e_valid || out_ready;
    assign d_ready  = !d_valid || e_ready;
    assign in_ready = d_ready;
    assign out_valid = e_valid;

    assign alu_operator = d_valid ? d_op : ALU_OPERATOR_ADD;
    assign alu_operand1 = d_valid ? d_op1 : '0;
    assign alu_operand2 = d_valid ? d_op2 : '0;

    always_comb begin
        e_result = alu_result;
`ifdef ALU_ISSUE_M_EXT_EN
        if (d_op2 == '0)
            e_result = (d_op == ALU_OPERATOR_DIV || d_op == ALU_OPERATOR_DIVU) ? '1 :
                       (d_op == ALU_OPERATOR_REM || d_op == ALU_OPERATOR_REMU) ? d_op1 : alu_result;
        else if (d_op1 == 32'h8000_0000 && d_op2 == '1)
            e_result = (d_op == ALU_OPERATOR_DIV) ? 32'h8000_0000 :
                       (d_op == ALU_OPERATOR_REM) ? 32'd0 : alu_result;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_valid           <= 1'b0;
            e_valid           <= 1'b0;
            out_rd            <= '0;
            out_rd_we         <= 1'b0;
            out_wb_data       <= '0;
            out_branch_taken  <= 1'b0;
            out_branch_target <= '0;
            out_illegal       <= 1'b0;
        end else begin
            if (d_ready) d_valid <= in_valid;
            if (in_valid && d_ready) begin
                d_op     <= dec_op;
                d_op1    <= dec_op1;
                d_op2    <= dec_op2;
                d_rd     <= rd;
                d_rd_we  <= dec_cls == CLS_ARITH && rd != 5'd0;
                d_cls    <= dec_cls;
                d_zsense <= dec_zsense;
                d_pc     <= in_pc;
                d_imm    <= imm_b;
            end
            if (e_ready) e_valid <= d_valid;
            if (d_valid && e_ready) begin
                out_rd            <= d_rd;
                out_rd_we         <= d_rd_we;
                out_wb_data       <= (d_cls == CLS_ARITH) ? e_result : '0;
                out_branch_taken  <= d_cls == CLS_BRANCH && alu_result_is_zero == d_zsense;
                out_branch_target <= (d_cls == CLS_BRANCH) ? d_pc + d_imm : '0;
                out_illegal       <= d_cls == CLS_ILLEGAL;
            end
        end
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issuer that sits in front of the combinational ALU. It accepts decoded-register-read RV32I instructions over a valid/ready handshake and registers them in a decode stage. It drives the ALU's operator and operands from that register, then captures the corrected result and branch outcome into an output stage that feeds writeback and fetch redirect.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction, pc and register operands are valid.
- in_ready  out  1  issuer accepts this cycle.
- in_instr  in  32  raw RV32 instruction.
- in_pc  in  32  instruction address.
- in_rs1_data, in_rs2_data  in  32 each  register-file read values.
- alu_operator  out  5  `ALU_OPERATOR_*` code from define.sv.
- alu_operand1, alu_operand2  out  32 each  ALU operands.
- alu_result  in  32  ALU result.
- alu_result_is_zero  in  1  ALU zero flag.
- out_valid  out  1  result stage holds a result.
- out_ready  in  1  consumer accepts.
- out_rd  out  5  destination register.
- out_rd_we  out  1  write enable; 0 for branches, illegal ops and rd=x0.
- out_wb_data  out  32  writeback value.
- out_branch_taken  out  1  conditional branch taken.
- out_branch_target  out  32  pc + B-immediate; 0 for non-branches.
- out_illegal  out  1  unsupported opcode or funct combination.

## Operation
- Two registered stages, D and E, each with a valid bit.
  - D holds the decoded fields: operator, op1, op2, rd, rd_we, class, pc and immediate.
  - E holds all out_* values.
- ALU ports are driven combinationally from D. When D is invalid, the ALU ports are driven with ADD, 0, 0.
- Supported opcodes:
  - OP: ADD/SUB/XOR/OR/SLL/SRL/SRA/SLT/SLTU. For shifts, alu_operand2 = {27'b0, rs2[4:0]}.
  - OP-IMM: ADDI/XORI/ORI/SLTI/SLTIU/SLLI/SRLI/SRAI. The immediate is sign-extended. Shifts use shamt = imm[4:0]. SRAI is selected by funct7 = 0100000.
  - LUI: ADD with 0 and the U-immediate.
  - AUIPC: ADD with pc and the U-immediate.
  - BRANCH, evaluated by ALU operator and zero flag:
    - BEQ and BNE use SUB. BEQ is taken when zero=1; BNE is taken when zero=0.
    - BLT and BGE use SLT. BLT is taken when zero=0; BGE is taken when zero=1.
    - BLTU and BGEU use SLTU, with the same rule as BLT and BGE.
- AND, ANDI and all other encodings are illegal. They have no ALU operator.
- An illegal instruction still flows through both stages with out_illegal=1, out_rd_we=0 and out_wb_data=0.
- out_wb_data = alu_result for arithmetic, LUI and AUIPC; it is 0 for branches.

## Timing
- Advance rules:
  - e_ready = !e_valid | out_ready.
  - d_ready = !d_valid | e_ready.
  - in_ready = d_ready.
- D loads on in_valid & in_ready. E loads from D on d_valid & e_ready.
- Latency: an input accepted at cycle N appears with out_valid at N+2. Throughput is 1 per cycle with no bubbles while out_ready=1.
- Backpressure:
  - out_valid=1 and out_ready=0 holds all out_* stable.
  - D then fills and holds. in_ready drops only when both stages are full.
- A simultaneous in handshake and D→E transfer in the same cycle replaces D without loss.
- Reset: both valid bits clear and all out_* registers go to 0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight instructions; no output is produced for them.

## Configuration
- ALU_ISSUE_M_EXT_EN defined: OP with funct7=0000001 decodes DIV/DIVU/REM/REMU. The E stage corrects the RISC-V corner cases so the ALU value is never forwarded:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - DIV of 0x80000000 by 0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
- MUL/MULH/MULHSU/MULHU are illegal.
- Not defined: every funct7=0000001 OP encoding is illegal and no division operator is ever issued.

## Test plan
- ADDI x5,x0,-1 at cycle 0 with out_ready=1 -> alu_operator=ADD, op2=0xFFFFFFFF; at cycle 2 out_valid=1, rd=5, wb=0xFFFFFFFF, rd_we=1.
- SLL with rs1=1 and rs2=0x00000023 -> alu_operand2=3, wb=0x8; SRAI shamt 4 on 0x80000000 -> wb=0xF8000000.
- BLTU at pc=0x100, imm=0x20, rs1=1, rs2=2 -> taken=1, target=0x120, rd_we=0; BGE with rs1=-1 and rs2=0 -> taken=0.
- Stream 4 back-to-back ADDs and hold out_ready=0 from cycle 3 for 3 cycles -> in_ready=0 while both stages are full; all 4 results emerge in order with none lost or duplicated; out_* stay stable while stalled.
- Assert rst with both stages full -> next cycle out_valid=0, all out_* = 0, in_ready=1; the discarded instructions never appear.
- With ALU_ISSUE_M_EXT_EN: DIV with rs2=0 -> wb=0xFFFFFFFF; REM of 0x80000000 by -1 -> wb=0; MUL -> illegal=1. Without the macro: DIVU -> illegal=1, rd_we=0.
